// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: D-PHY style HS burst framing (prep, sync, payload, trail, exit) ahead of a byte serializer.
module hs_tx_sequencer #(
  parameter int          PREP_CYCLES  = 4,
  parameter int          TRAIL_CYCLES = 3,
  parameter logic [7:0]  SYNC_WORD    = 8'hB8
) (
  input  logic        TxByteClk,
  input  logic        TxRst,
  input  logic        TxRequestHS,
  input  logic [7:0]  TxDataHS,
  output logic        TxReadyHS,
  output logic        HSTX_EN,
  output logic [7:0]  DataIn,
  output logic [2:0]  DphyTxState,
  output logic [15:0] ByteCount
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    SYNC  = 3'd2,
    DATA  = 3'd3,
    TRAIL = 3'd4,
    EXIT  = 3'd5
  } state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [7:0] data_q;
  logic accept;
  assign TxReadyHS   = (state == SYNC) || (state == DATA);
  assign accept      = TxReadyHS && TxRequestHS;
  assign HSTX_EN     = (state == PREP) || (state == SYNC) || (state == DATA) || (state == TRAIL);
  assign DphyTxState = state;
  // data_q holds the last byte on the line (sync word or payload), which also picks trail polarity
  assign DataIn      = TxReadyHS ? data_q : (state == TRAIL) ? {8{~data_q[7]}} : 8'h00;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:       next = TxRequestHS ? PREP : IDLE;
      PREP:       next = (cnt == 4'd0) ? SYNC : PREP;
      SYNC, DATA: next = TxRequestHS ? DATA : TRAIL;
      TRAIL:      next = (cnt == 4'd0) ? EXIT : TRAIL;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge TxByteClk) begin
    if (TxRst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data_q    <= 8'h00;
      ByteCount <= 16'h0000;
    end else begin
      state <= next;
      cnt <= (state == IDLE && next == PREP) ? 4'(PREP_CYCLES - 1) :
             (state != TRAIL && next == TRAIL) ? 4'(TRAIL_CYCLES - 1) :
             (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
      data_q <= (state == PREP && next == SYNC) ? SYNC_WORD : accept ? TxDataHS : data_q;
      ByteCount <= (state == IDLE && next == PREP) ? 16'h0000 :
                   (accept && ByteCount != 16'hFFFF) ? ByteCount + 16'd1 : ByteCount;
    end
  end
endmodule

// File: tb/tb_hs_tx_sequencer.sv
// tb_hs_tx_sequencer: directed burst vectors against hand-computed line sequences.
module tb_hs_tx_sequencer;
  logic        clk = 1'b0;
  logic        rst, req;
  logic [7:0]  data;
  logic        rdy, en;
  logic [7:0]  din;
  logic [2:0]  st;
  logic [15:0] bc;
  int          n_chk = 0, n_fail = 0;

  hs_tx_sequencer dut (
    .TxByteClk(clk), .TxRst(rst), .TxRequestHS(req), .TxDataHS(data),
    .TxReadyHS(rdy), .HSTX_EN(en), .DataIn(din), .DphyTxState(st), .ByteCount(bc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e, input logic r, input logic [2:0] s, input logic [7:0] d);
    check(tag, {20'd0, en, rdy, st, din}, {20'd0, e, r, s, d});
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    chk_out("reset", 0, 0, 0, 8'h00);
    check("reset_bc", {16'd0, bc}, 0);
    rst = 1'b0;
  endtask

  task automatic run_burst(input string tag, input int n, input logic [7:0] b [8],
                           input logic [7:0] trail, input bit hold);
    req  = 1'b1;
    data = (n > 0) ? b[0] : 8'h00;
    for (int i = 0; i < 4; i++) begin
      step;
      chk_out({tag, "_prep"}, 1, 0, 1, 8'h00);
      if (n == 0) req = 1'b0;
    end
    step;
    chk_out({tag, "_sync"}, 1, 1, 2, 8'hB8);
    for (int i = 0; i < n; i++) begin
      step;
      chk_out({tag, "_data"}, 1, 1, 3, b[i]);
      if (i + 1 < n) data = b[i + 1];
      else req = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      step;
      chk_out({tag, "_trail"}, 1, 0, 4, trail);
      check({tag, "_trail_bc"}, {16'd0, bc}, n);
      if (hold && i == 2) req = 1'b1;
    end
    step;
    chk_out({tag, "_exit"}, 0, 0, 5, 8'h00);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 1'b0;
    data = 8'h00;
    step;
    do_reset;
    step;
    chk_out("idle", 0, 0, 0, 8'h00);

    run_burst("basic", 3, '{8'h11, 8'h22, 8'h83, 0, 0, 0, 0, 0}, 8'h00, 0);
    step;
    chk_out("basic_idle", 0, 0, 0, 8'h00);
    check("basic_hold_bc", {16'd0, bc}, 3);

    run_burst("pol", 1, '{8'h7F, 0, 0, 0, 0, 0, 0, 0}, 8'hFF, 0);
    step;
    run_burst("empty", 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'h00, 0);
    step;
    run_burst("mixed", 4, '{8'hA5, 8'h00, 8'hFF, 8'h01, 0, 0, 0, 0}, 8'hFF, 0);
    step;

    run_burst("b2b", 2, '{8'h90, 8'h80, 0, 0, 0, 0, 0, 0}, 8'h00, 1);
    step;
    chk_out("b2b_idle", 0, 0, 0, 8'h00);
    check("b2b_idle_bc", {16'd0, bc}, 2);
    step;
    chk_out("b2b_prep", 1, 0, 1, 8'h00);
    check("b2b_prep_bc", {16'd0, bc}, 0);
    do_reset;

    req  = 1'b1;
    data = 8'hAA;
    for (int i = 0; i < 5; i++) step;
    chk_out("mid_sync", 1, 1, 2, 8'hB8);
    step;
    data = 8'h3C;
    step;
    chk_out("mid_data", 1, 1, 3, 8'h3C);
    check("mid_bc", {16'd0, bc}, 2);
    rst = 1'b1;
    step;
    chk_out("mid_reset", 0, 0, 0, 8'h00);
    check("mid_reset_bc", {16'd0, bc}, 0);
    rst = 1'b0;
    step;
    chk_out("rst_release_prep", 1, 0, 1, 8'h00);
    do_reset;

    req  = 1'b1;
    data = 8'd3;
    for (int i = 0; i < 5; i++) step;
    for (int i = 0; i < 65540; i++) begin
      step;
      if (i >= 65530) begin
        check("sat_data", {24'd0, din}, {24'd0, 8'(i * 7 + 3)});
        check("sat_bc", {16'd0, bc}, (i + 1 > 65535) ? 65535 : i + 1);
      end
      data = 8'((i + 1) * 7 + 3);
    end
    req = 1'b0;
    step;
    chk_out("sat_trail", 1, 0, 4, 8'hFF);
    check("sat_trail_bc", {16'd0, bc}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
